// File: rtl/dec_ctrl.sv
// dec_ctrl: decode-stage controller for the rv32 pipeline.
// Classifies the IF/ID instruction, detects RAW hazards against the EX register and
// the MEM shadow, and sequences the ID/EX control register (stall, bubble, flush).
// Build option: define DEC_CTRL_FWD_EN when EX forwards results; only load-use then
// stalls. Left undefined, any pending write in EX or MEM to a used source stalls.
module dec_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic [2:0]       ex_imm_sel,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_we,
    output logic             ex_mem_rd,
    output logic             ex_mem_wr,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] ImmR = 3'd0;
    localparam logic [2:0] ImmI = 3'd1;
    localparam logic [2:0] ImmS = 3'd2;
    localparam logic [2:0] ImmB = 3'd3;
    localparam logic [2:0] ImmU = 3'd4;
    localparam logic [2:0] ImmJ = 3'd5;

    // What the EX register does on the next edge
    typedef enum logic [1:0] {ActHold, ActBubble, ActLoad} act_e;

    // Decoded fields of the IF/ID instruction
    logic [6:0] opcode;
    logic [4:0] idRs1, idRs2, idRd;
    logic [2:0] decImmSel;
    logic       decUseRs1, decUseRs2;
    logic       decRegWe, decMemRd, decMemWr, decIllegal;

    // ID/EX register
    logic       exValidQ, exValidD;
    logic [2:0] exImmSelQ, exImmSelD;
    logic [4:0] exRs1Q, exRs1D;
    logic [4:0] exRs2Q, exRs2D;
    logic [4:0] exRdQ, exRdD;
    logic       exRegWeQ, exRegWeD;
    logic       exMemRdQ, exMemRdD;
    logic       exMemWrQ, exMemWrD;
    logic       exIllegalQ, exIllegalD;

    // MEM shadow: the instruction that left EX on the previous advance
    logic       memValidQ, memValidD;
    logic [4:0] memRdQ, memRdD;
    logic       memRegWeQ, memRegWeD;

    logic [CNT_W-1:0] stallCntQ, stallCntD;

    logic exHit, memHit, loadUse, hazard;
    logic idReadyRaw, stallInc;
    act_e act;

    // Funct fields and upper immediate bits play no part in control decode
    logic unusedInstrBits;
    assign unusedInstrBits = ^{id_instr[31:25], id_instr[14:12]};

    assign opcode = id_instr[6:0];
    assign idRs1  = id_instr[19:15];
    assign idRs2  = id_instr[24:20];
    assign idRd   = id_instr[11:7];

    // Opcode decode: immediate format, used sources and pipeline enables
    always_comb begin
        decImmSel  = ImmR;
        decUseRs1  = 1'b0;
        decUseRs2  = 1'b0;
        decRegWe   = 1'b0;
        decMemRd   = 1'b0;
        decMemWr   = 1'b0;
        decIllegal = 1'b0;
        case (opcode)
            OpR: begin
                decImmSel = ImmR;
                decUseRs1 = 1'b1;
                decUseRs2 = 1'b1;
                decRegWe  = 1'b1;
            end
            OpImm, OpJalr: begin
                decImmSel = ImmI;
                decUseRs1 = 1'b1;
                decRegWe  = 1'b1;
            end
            OpLoad: begin
                decImmSel = ImmI;
                decUseRs1 = 1'b1;
                decRegWe  = 1'b1;
                decMemRd  = 1'b1;
            end
            OpStore: begin
                decImmSel = ImmS;
                decUseRs1 = 1'b1;
                decUseRs2 = 1'b1;
                decMemWr  = 1'b1;
            end
            OpBranch: begin
                decImmSel = ImmB;
                decUseRs1 = 1'b1;
                decUseRs2 = 1'b1;
            end
            OpLui, OpAuipc: begin
                decImmSel = ImmU;
                decRegWe  = 1'b1;
            end
            OpJal: begin
                decImmSel = ImmJ;
                decRegWe  = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Source-match against older destinations; x0 never creates a dependency
    always_comb begin
        exHit  = (exRdQ != 5'd0) &&
                 ((decUseRs1 && (exRdQ == idRs1)) || (decUseRs2 && (exRdQ == idRs2)));
        memHit = (memRdQ != 5'd0) &&
                 ((decUseRs1 && (memRdQ == idRs1)) || (decUseRs2 && (memRdQ == idRs2)));
        loadUse = exValidQ && exMemRdQ && exHit;
`ifdef DEC_CTRL_FWD_EN
        hazard = loadUse;
`else
        // WB writes are visible to same-cycle reads, so only EX and MEM matter
        hazard = loadUse || (exValidQ && exRegWeQ && exHit) ||
                 (memValidQ && memRegWeQ && memHit);
`endif
    end

    // Per-cycle priority: freeze, flush, hazard stall, issue, idle bubble
    always_comb begin
        act        = ActBubble;
        idReadyRaw = 1'b0;
        stallInc   = 1'b0;
        if (!ex_ready) begin
            act = ActHold;
        end else if (ex_flush) begin
            act        = ActBubble;
            idReadyRaw = id_valid;
        end else if (id_valid && hazard) begin
            act      = ActBubble;
            stallInc = 1'b1;
        end else if (id_valid) begin
            act        = ActLoad;
            idReadyRaw = 1'b1;
        end
    end

    assign id_ready = idReadyRaw && !rst;

    // Next state of the EX register, MEM shadow and stall counter
    always_comb begin
        exValidD   = exValidQ;
        exImmSelD  = exImmSelQ;
        exRs1D     = exRs1Q;
        exRs2D     = exRs2Q;
        exRdD      = exRdQ;
        exRegWeD   = exRegWeQ;
        exMemRdD   = exMemRdQ;
        exMemWrD   = exMemWrQ;
        exIllegalD = exIllegalQ;
        memValidD  = memValidQ;
        memRdD     = memRdQ;
        memRegWeD  = memRegWeQ;
        stallCntD  = stallCntQ;

        if (act != ActHold) begin
            memValidD = exValidQ;
            memRdD    = exRdQ;
            memRegWeD = exRegWeQ;
        end

        case (act)
            ActLoad: begin
                exValidD   = 1'b1;
                exImmSelD  = decImmSel;
                exRs1D     = idRs1;
                exRs2D     = idRs2;
                exRdD      = idRd;
                exRegWeD   = decRegWe;
                exMemRdD   = decMemRd;
                exMemWrD   = decMemWr;
                exIllegalD = decIllegal;
            end
            ActBubble: begin
                // Bubbles clear the index fields too so they never match downstream
                exValidD   = 1'b0;
                exImmSelD  = 3'd0;
                exRs1D     = 5'd0;
                exRs2D     = 5'd0;
                exRdD      = 5'd0;
                exRegWeD   = 1'b0;
                exMemRdD   = 1'b0;
                exMemWrD   = 1'b0;
                exIllegalD = 1'b0;
            end
            default: ;
        endcase

        if (stallInc && (stallCntQ != {CNT_W{1'b1}})) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            exValidQ   <= 1'b0;
            exImmSelQ  <= 3'd0;
            exRs1Q     <= 5'd0;
            exRs2Q     <= 5'd0;
            exRdQ      <= 5'd0;
            exRegWeQ   <= 1'b0;
            exMemRdQ   <= 1'b0;
            exMemWrQ   <= 1'b0;
            exIllegalQ <= 1'b0;
            memValidQ  <= 1'b0;
            memRdQ     <= 5'd0;
            memRegWeQ  <= 1'b0;
            stallCntQ  <= '0;
        end else begin
            exValidQ   <= exValidD;
            exImmSelQ  <= exImmSelD;
            exRs1Q     <= exRs1D;
            exRs2Q     <= exRs2D;
            exRdQ      <= exRdD;
            exRegWeQ   <= exRegWeD;
            exMemRdQ   <= exMemRdD;
            exMemWrQ   <= exMemWrD;
            exIllegalQ <= exIllegalD;
            memValidQ  <= memValidD;
            memRdQ     <= memRdD;
            memRegWeQ  <= memRegWeD;
            stallCntQ  <= stallCntD;
        end
    end

    assign ex_valid    = exValidQ;
    assign ex_imm_sel  = exImmSelQ;
    assign ex_rs1      = exRs1Q;
    assign ex_rs2      = exRs2Q;
    assign ex_rd       = exRdQ;
    assign ex_reg_we   = exRegWeQ;
    assign ex_mem_rd   = exMemRdQ;
    assign ex_mem_wr   = exMemWrQ;
    assign ex_illegal  = exIllegalQ;
    assign stall_count = stallCntQ;

endmodule

// File: tb/tb_dec_ctrl.sv
// Scoreboard bench for dec_ctrl: accepted instructions push their expected EX image,
// a monitor pops and compares each time the EX register advances with a valid entry.
module tb_dec_ctrl;

    localparam int unsigned CntW = 3;
    localparam int CntMax = 7;
`ifdef DEC_CTRL_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] immSel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regWe;
        logic       memRd;
        logic       memWr;
        logic       illegal;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic            id_ready;
    logic            ex_ready;
    logic            ex_flush;
    logic            ex_valid;
    logic [2:0]      ex_imm_sel;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal;
    logic [CntW-1:0] stall_count;

    int   checks = 0;
    int   failures = 0;
    int   expCnt = 0;
    exp_t q[$];
    logic adv = 1'b0;
    exp_t actual;

    dec_ctrl #(.CNT_W(CntW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
        .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_imm_sel(ex_imm_sel), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_illegal(ex_illegal), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign actual = {ex_imm_sel, ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr,
                     ex_illegal};

    // Remember whether the EX register was allowed to advance at this edge
    always @(posedge clk) adv <= !rst && ex_ready;

    // Monitor: every advance that leaves a valid entry must match the next expectation
    always @(negedge clk) begin
        if (adv && ex_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL ex_out: unexpected entry %h, queue empty", actual);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (actual !== e) begin
                    failures++;
                    $display("FAIL ex_out: got %h want %h", actual, e);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] opc, input int rd, input int rs1,
                                       input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), opc};
    endfunction

    function automatic exp_t ex(input int imm, input int rs1, input int rs2, input int rd,
                                input bit we, input bit mrd, input bit mwr, input bit ill);
        exp_t e;
        e.immSel = 3'(imm);
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.rd = 5'(rd);
        e.regWe = we;
        e.memRd = mrd;
        e.memWr = mwr;
        e.illegal = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Present one instruction from a negedge until accepted; count the stall cycles
    task automatic send(input logic [31:0] instr, input exp_t e, input int expStalls,
                        input string name);
        int  stalls = 0;
        bit  done = 1'b0;
        id_valid = 1'b1;
        id_instr = instr;
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            if (id_ready) begin
                q.push_back(e);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        id_valid = 1'b0;
        checks++;
        if (!done || stalls != expStalls) begin
            failures++;
            $display("FAIL %s stalls: got %0d (accepted=%0d) want %0d", name, stalls, done,
                     expStalls);
        end
        expCnt = (expCnt + expStalls > CntMax) ? CntMax : expCnt + expStalls;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int lu;  // stall cycles for a load followed by a dependent use

    initial begin
        lu = FwdEn ? 1 : 2;
        rst = 1'b1;
        id_valid = 1'b1;
        id_instr = 32'h0072_8333;
        ex_ready = 1'b1;
        ex_flush = 1'b0;

        // Reset held for two cycles with a valid instruction presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ex_fields", 32'(actual), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_count), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd0);
        rst = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);

        // Decode sweep; unused source fields deliberately alias recent destinations
        send(mk(7'b0110011, 20, 10, 11), ex(0, 10, 11, 20, 1, 0, 0, 0), 0, "dec_r");
        send(mk(7'b0010011, 21, 12, 3), ex(1, 12, 3, 21, 1, 0, 0, 0), 0, "dec_opimm");
        send(mk(7'b0000011, 22, 13, 0), ex(1, 13, 0, 22, 1, 1, 0, 0), 0, "dec_load");
        send(mk(7'b1100111, 23, 14, 0), ex(1, 14, 0, 23, 1, 0, 0, 0), 0, "dec_jalr");
        send(mk(7'b0100011, 5, 10, 11), ex(2, 10, 11, 5, 0, 0, 1, 0), 0, "dec_store");
        send(mk(7'b1100011, 6, 12, 13), ex(3, 12, 13, 6, 0, 0, 0, 0), 0, "dec_branch");
        send(mk(7'b0110111, 24, 20, 21), ex(4, 20, 21, 24, 1, 0, 0, 0), 0, "dec_lui");
        send(mk(7'b0010111, 25, 24, 24), ex(4, 24, 24, 25, 1, 0, 0, 0), 0, "dec_auipc");
        send(mk(7'b1101111, 26, 25, 0), ex(5, 25, 0, 26, 1, 0, 0, 0), 0, "dec_jal");
        send(mk(7'b0001011, 27, 26, 26), ex(0, 26, 26, 27, 0, 0, 0, 1), 0, "dec_illegal");
        #1 chk("sweep_stall_cnt", 32'(stall_count), 32'(expCnt));

        // Load-use: lw x5,0(x1) then add x6,x5,x7
        send(32'h0000_A283, ex(1, 1, 0, 5, 1, 1, 0, 0), 0, "lu_lw");
        send(32'h0072_8333, ex(0, 5, 7, 6, 1, 0, 0, 0), lu, "lu_add");
        #1 chk("lu_stall_cnt", 32'(stall_count), 32'(expCnt));

        // Same with rd=x0: no dependency
        send(32'h0000_A003, ex(1, 1, 0, 0, 1, 1, 0, 0), 0, "lu0_lw");
        send(32'h0070_0333, ex(0, 0, 7, 6, 1, 0, 0, 0), 0, "lu0_add");
        #1 chk("lu0_stall_cnt", 32'(stall_count), 32'(expCnt));

        // Flush while a load-use hazard is pending
        send(mk(7'b0000011, 8, 1, 0), ex(1, 1, 0, 8, 1, 1, 0, 0), 0, "fl_lw");
        id_valid = 1'b1;
        id_instr = mk(7'b0110011, 9, 8, 8);
        ex_flush = 1'b1;
        #1 chk("fl_id_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ex_flush = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("fl_bubble", 32'(ex_valid), 32'd0);
        chk("fl_stall_cnt", 32'(stall_count), 32'(expCnt));
        idle(2);

        // Backpressure: freeze with EX=A, MEM=C; B depends on C
        send(mk(7'b0010011, 18, 10, 0), ex(1, 10, 0, 18, 1, 0, 0, 0), 0, "bp_c");
        send(mk(7'b0110011, 16, 11, 12), ex(0, 11, 12, 16, 1, 0, 0, 0), 0, "bp_a");
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = mk(7'b0010011, 17, 18, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", 32'(id_ready), 32'd0);
            chk("bp_ex_rd", 32'(ex_rd), 32'd16);
            chk("bp_ex_valid", 32'(ex_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        ex_ready = 1'b1;
        send(mk(7'b0010011, 17, 18, 0), ex(1, 18, 0, 17, 1, 0, 0, 0), FwdEn ? 0 : 1, "bp_b");
        #1 chk("bp_stall_cnt", 32'(stall_count), 32'(expCnt));
        idle(2);

        // Back-to-back dependent ALU ops: addi x5,x0,1 then add x6,x5,x5
        send(32'h0010_0293, ex(1, 0, 1, 5, 1, 0, 0, 0), 0, "b2b_addi");
        send(32'h0052_8333, ex(0, 5, 5, 6, 1, 0, 0, 0), FwdEn ? 0 : 2, "b2b_add");
        #1 chk("b2b_stall_cnt", 32'(stall_count), 32'(expCnt));

        // Drive the counter into saturation
        for (int i = 0; i < 8; i++) begin
            send(32'h0000_A283, ex(1, 1, 0, 5, 1, 1, 0, 0), 0, "sat_lw");
            send(32'h0072_8333, ex(0, 5, 7, 6, 1, 0, 0, 0), lu, "sat_add");
            #1 chk("sat_stall_cnt", 32'(stall_count), 32'(expCnt));
        end

        // Reset in the middle of a load-use stall
        send(32'h0000_A283, ex(1, 1, 0, 5, 1, 1, 0, 0), 0, "rs_lw");
        id_valid = 1'b1;
        id_instr = 32'h0072_8333;
        #1 chk("rs_stalling", 32'(id_ready), 32'd0);
        rst = 1'b1;
        #1 chk("rs_id_ready", 32'(id_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b0;
        expCnt = 0;
        #1;
        chk("rs_ex_valid", 32'(ex_valid), 32'd0);
        chk("rs_stall_cnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        send(32'h0072_8333, ex(0, 5, 7, 6, 1, 0, 0, 0), 0, "rs_add");
        #1 chk("rs_stall_cnt_after", 32'(stall_count), 32'd0);

        idle(3);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dec_ctrl.md
# dec_ctrl

Decode-stage controller for the rv32 pipeline. Classifies the IF/ID instruction into an immediate-format select, detects RAW hazards against the instructions it has already issued, and sequences the ID/EX control register with stall, bubble and flush. It sits between the IF/ID register and the EX stage, and drives the immediate generator's select input one cycle ahead of EX use.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds an instruction
- id_instr  in  32  IF/ID instruction word
- id_ready  out  1  instruction consumed this cycle
- ex_ready  in  1  EX accepts the ID/EX contents; 0 freezes the block
- ex_flush  in  1  branch/jump taken in EX; kill the ID instruction
- ex_valid  out  1  ID/EX holds a real instruction
- ex_imm_sel  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J
- ex_rs1, ex_rs2, ex_rd  out  5  register indices
- ex_reg_we, ex_mem_rd, ex_mem_wr  out  1  EX/MEM/WB controls
- ex_illegal  out  1  opcode not in the decode list
- stall_count  out  CNT_W  hazard stall cycles, saturating

## Operation
- Decode on opcode = id_instr[6:0]:
  - 0110011 -> R (0); rs1, rs2, rd used; reg_we.
  - 0010011 -> I (1); rs1; reg_we.
  - 0000011 -> I (1); rs1; reg_we, mem_rd.
  - 1100111 -> I (1); rs1; reg_we.
  - 0100011 -> S (2); rs1, rs2; mem_wr.
  - 1100011 -> B (3); rs1, rs2.
  - 0110111 and 0010111 -> U (4); reg_we.
  - 1101111 -> J (5); reg_we.
  - Any other opcode -> imm_sel 0, no write or memory enables, illegal=1.
- rs1/rs2/rd fields are always copied from instr[19:15]/[24:20]/[11:7]. Hazard checks consider only sources the format uses, and ignore index 0.
- An internal MEM shadow (mem_valid, mem_rd, mem_reg_we) copies the EX register whenever the EX register advances.
- Load-use hazard: ex_valid & ex_mem_rd & ex_rd≠0 & ex_rd matches a used source.
- Per-cycle priority, highest first:
  1. rst: all outputs 0, shadow cleared, stall_count=0.
  2. !ex_ready: hold the EX register and shadow; id_ready=0. ex_flush is ignored while !ex_ready.
  3. ex_flush: the EX register loads a bubble (ex_valid=0, all enables 0); the shadow advances; id_ready=id_valid (wrong-path instruction dropped).
  4. id_valid & hazard: the EX register loads a bubble; id_ready=0; stall_count increments and saturates at all-ones.
  5. id_valid: load the decoded instruction; ex_valid=1; id_ready=1.
  6. !id_valid: the EX register loads a bubble.
- id_ready is combinational from the current inputs and registered state.
- A bubble still latches imm_sel/rs/rd fields as 0.

## Timing
- Decode-to-EX latency is 1 cycle: an instruction accepted at edge N is visible on the ex_* outputs after edge N.
- A load-use stall costs exactly 1 cycle. With forwarding disabled, see Configuration.
- Reset value is 0 for every output, and id_ready=0 while rst is high.
- Reset mid-stall or mid-flush: the next cycle starts from an empty pipeline, and no stall is carried over.
- A hazard coinciding with ex_flush resolves as a flush: no stall is counted.

## Configuration
- DEC_CTRL_FWD_EN defined (forwarding present in EX): only the load-use hazard stalls.
- DEC_CTRL_FWD_EN undefined: the hazard term also covers these cases, with WB writes assumed visible to same-cycle reads:
  - (ex_valid & ex_reg_we & ex_rd≠0 & ex_rd matches a used source)
  - (mem_valid & mem_reg_we & mem_rd≠0 & mem_rd matches a used source)
- Back-to-back dependent ALU ops therefore stall 2 cycles.

## Test plan
- Reset: hold rst=1 for 2 cycles with id_valid=1 -> all ex_* = 0, stall_count=0, id_ready=0.
- Decode sweep: apply one instruction of each listed opcode with ex_ready=1 -> the next cycle shows the correct imm_sel (0..5) and enables. Opcode 0001011 -> ex_illegal=1, ex_reg_we=0.
- Load-use: lw x5,0(x1) (0x0000A283), then add x6,x5,x7 (0x00728333) -> one bubble with id_ready=0 for 1 cycle, the add issues on the next cycle, stall_count=1. The same sequence with rd=x0 -> no stall.
- Flush: ex_flush=1 while id_valid=1 and a hazard is present -> the EX register becomes a bubble, id_ready=1, stall_count unchanged.
- Backpressure: ex_ready=0 for 3 cycles mid-stream -> ex_* frozen, id_ready=0, the shadow is unchanged, and the stream resumes with no lost or duplicated instruction.
- Without DEC_CTRL_FWD_EN: addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333) -> 2 stall cycles, stall_count=2. With the macro defined -> 0 stalls.
